// File: rtl/clock_set_pkg.sv
// Shared encodings and limits for the clock set/run front-end controller.
package clock_set_pkg;

  localparam logic [1:0] CH_OFF      = 2'b00;
  localparam logic [1:0] CH_SET_MIN  = 2'b01;
  localparam logic [1:0] CH_SET_HOUR = 2'b10;
  localparam logic [1:0] CH_RUN      = 2'b11;

  // State encoding equals the choice code so the output is a direct copy.
  typedef logic [1:0] state_t;

  localparam state_t ST_OFF      = CH_OFF;
  localparam state_t ST_SET_MIN  = CH_SET_MIN;
  localparam state_t ST_SET_HOUR = CH_SET_HOUR;
  localparam state_t ST_RUN      = CH_RUN;

  localparam logic [5:0] MIN_MAX  = 6'd59;
  localparam logic [5:0] HOUR_MAX = 6'd23;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, stability counter and armed rising-edge press pulse for one raw input.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_level,
  output logic o_press
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      r_sync;
  logic            r_prev;
  logic [CntW-1:0] r_cnt;
  logic            r_level;
  logic            r_level_q;
  logic            r_armed;

  // r_armed is set only once a stable low is accepted, so a button held
  // through reset release cannot produce a press until it is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync    <= 2'b00;
      r_prev    <= 1'b0;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_level_q <= 1'b0;
      r_armed   <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], i_btn};
      r_prev    <= r_sync[1];
      r_level_q <= r_level;
      if (r_sync[1] != r_prev) begin
        r_cnt <= '0;
      end else if (r_cnt == CntLast) begin
        r_level <= r_sync[1];
        if (!r_sync[1]) begin
          r_armed <= 1'b1;
        end
      end else begin
        r_cnt <= r_cnt + CntW'(1);
      end
    end
  end

  assign o_level = r_level;
  assign o_press = r_level & ~r_level_q & r_armed;

endmodule

// File: rtl/clock_set_ctrl.sv
// Mode FSM and BCD field editor driving the HH:MM:SS clock set interface.
// Optional auto-repeat of held inc/dec is enabled by defining AUTO_REPEAT_EN.
module clock_set_ctrl
  import clock_set_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_power_sw,
  input  logic       i_btn_mode,
  input  logic       i_btn_inc,
  input  logic       i_btn_dec,
  output logic [1:0] o_choice,
  output logic [3:0] o_data_0,
  output logic [3:0] o_data_1,
  output logic       o_load
);

  logic w_pwr_lvl;
  logic w_mode_press;
  logic w_inc_lvl, w_inc_press;
  logic w_dec_lvl, w_dec_press;
  logic w_inc_ev, w_dec_ev;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_pwr (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_btn   (i_power_sw),
    .o_level (w_pwr_lvl),
    .o_press ()
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_btn   (i_btn_mode),
    .o_level (),
    .o_press (w_mode_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_btn   (i_btn_inc),
    .o_level (w_inc_lvl),
    .o_press (w_inc_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dec (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_btn   (i_btn_dec),
    .o_level (w_dec_lvl),
    .o_press (w_dec_press)
  );

  state_t     r_state, w_state_d;
  logic [5:0] r_min, r_hour, w_min_d, w_hour_d;
  logic       w_edit_ok;

  always_comb begin
    w_state_d = r_state;
    if (!w_pwr_lvl) begin
      w_state_d = ST_OFF;
    end else begin
      case (r_state)
        ST_OFF:      w_state_d = ST_RUN;
        ST_RUN:      if (w_mode_press) w_state_d = ST_SET_MIN;
        ST_SET_MIN:  if (w_mode_press) w_state_d = ST_SET_HOUR;
        ST_SET_HOUR: if (w_mode_press) w_state_d = ST_RUN;
        default:     w_state_d = ST_OFF;
      endcase
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RepW   = $clog2(RepMax + 1);

  logic [RepW-1:0] r_rep_cnt;
  logic            r_rep_active;
  logic            w_rep_hold, w_rep_hit, w_rep_step;

  // Timer runs only while exactly one of inc/dec is held in a stable SET state.
  assign w_rep_hold = w_pwr_lvl && (w_inc_lvl ^ w_dec_lvl) && (w_state_d == r_state) &&
                      ((r_state == ST_SET_MIN) || (r_state == ST_SET_HOUR));
  assign w_rep_hit  = (r_rep_cnt == (r_rep_active ? RepW'(REPEAT_PERIOD) : RepW'(REPEAT_DELAY)));
  assign w_rep_step = w_rep_hold && w_rep_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rep_cnt    <= '0;
      r_rep_active <= 1'b0;
    end else if (!w_rep_hold) begin
      r_rep_cnt    <= '0;
      r_rep_active <= 1'b0;
    end else if (w_rep_hit) begin
      r_rep_cnt    <= RepW'(1);
      r_rep_active <= 1'b1;
    end else begin
      r_rep_cnt <= r_rep_cnt + RepW'(1);
    end
  end

  assign w_inc_ev = w_inc_press | (w_rep_step & w_inc_lvl);
  assign w_dec_ev = w_dec_press | (w_rep_step & w_dec_lvl);
`else
  assign w_inc_ev = w_inc_press;
  assign w_dec_ev = w_dec_press;
`endif

  // Mode press or loss of power wins over edits; simultaneous inc/dec cancel.
  assign w_edit_ok = w_pwr_lvl && !w_mode_press && (w_inc_ev ^ w_dec_ev);

  always_comb begin
    w_min_d  = r_min;
    w_hour_d = r_hour;
    if (w_edit_ok && (r_state == ST_SET_MIN)) begin
      if (w_inc_ev) w_min_d = (r_min == MIN_MAX) ? 6'd0 : r_min + 6'd1;
      else          w_min_d = (r_min == 6'd0) ? MIN_MAX : r_min - 6'd1;
    end
    if (w_edit_ok && (r_state == ST_SET_HOUR)) begin
      if (w_inc_ev) w_hour_d = (r_hour == HOUR_MAX) ? 6'd0 : r_hour + 6'd1;
      else          w_hour_d = (r_hour == 6'd0) ? HOUR_MAX : r_hour - 6'd1;
    end
  end

  logic [5:0] w_sel;
  logic [3:0] w_tens, w_ones;
  logic       w_load_d;

  always_comb begin
    case (w_state_d)
      ST_SET_MIN:  w_sel = w_min_d;
      ST_SET_HOUR: w_sel = w_hour_d;
      default:     w_sel = 6'd0;
    endcase
  end

  always_comb begin
    if      (w_sel >= 6'd50) w_tens = 4'd5;
    else if (w_sel >= 6'd40) w_tens = 4'd4;
    else if (w_sel >= 6'd30) w_tens = 4'd3;
    else if (w_sel >= 6'd20) w_tens = 4'd2;
    else if (w_sel >= 6'd10) w_tens = 4'd1;
    else                     w_tens = 4'd0;
  end

  // Remainder is below 10, so modulo-16 arithmetic on the low nibble is exact.
  assign w_ones   = w_sel[3:0] - 4'(w_tens * 4'd10);
  assign w_load_d = (w_state_d != o_choice) || (w_tens != o_data_1) || (w_ones != o_data_0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_OFF;
      r_min    <= 6'd0;
      r_hour   <= 6'd0;
      o_choice <= CH_OFF;
      o_data_1 <= 4'd0;
      o_data_0 <= 4'd0;
      o_load   <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_min    <= w_min_d;
      r_hour   <= w_hour_d;
      o_choice <= w_state_d;
      o_data_1 <= w_tens;
      o_data_0 <= w_ones;
      o_load   <= w_load_d;
    end
  end

endmodule
